move_scheduler: RTL

Converts the held-direction flags from the keyboard decoder into discrete, rate-controlled move commands for the game logic. It resolves simultaneous keys and applies first-press, initial-delay and auto-repeat sequencing. Each move is issued over a valid/ready handshake, and the block maintains the resulting player grid position. It sits between the keyboard decoder's 4-bit direction output and the game-state/render logic.

---
 rtl/move_pkg.sv | 59 +++++
 rtl/move_scheduler_tick_prescaler.sv | 32 +++
 rtl/move_scheduler.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/move_pkg.sv
// move_pkg: shared encodings for the movement path.
// Holds the 2-bit move direction codes, the scheduler state enum, the bit
// positions of the keyboard decoder's held-direction flags, and the
// combinational direction resolver used by move_scheduler.
package move_pkg;

   // Move direction codes presented on move_dir
   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   // Bit positions inside the decoder's 4-bit held-direction vector
   localparam int DIR_BIT_UP    = 3;
   localparam int DIR_BIT_DOWN  = 2;
   localparam int DIR_BIT_LEFT  = 1;
   localparam int DIR_BIT_RIGHT = 0;

   // Scheduler states; explicit codes keep the encoding stable for debug taps
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } move_state_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] dir;
   } resolved_t;

   // Opposing keys on one axis cancel that axis; survivors resolve by
   // priority up > down > left > right.
   function automatic resolved_t resolve_dir(input logic [3:0] flags);
      logic      up_eff;
      logic      down_eff;
      logic      left_eff;
      logic      right_eff;
      resolved_t res;
      up_eff    = flags[DIR_BIT_UP]    & ~flags[DIR_BIT_DOWN];
      down_eff  = flags[DIR_BIT_DOWN]  & ~flags[DIR_BIT_UP];
      left_eff  = flags[DIR_BIT_LEFT]  & ~flags[DIR_BIT_RIGHT];
      right_eff = flags[DIR_BIT_RIGHT] & ~flags[DIR_BIT_LEFT];
      res.valid = 1'b1;
      if (up_eff)
         res.dir = DIR_UP;
      else if (down_eff)
         res.dir = DIR_DOWN;
      else if (left_eff)
         res.dir = DIR_LEFT;
      else if (right_eff)
         res.dir = DIR_RIGHT;
      else begin
         res.valid = 1'b0;
         res.dir   = DIR_UP;
      end
      return res;
   endfunction

endpackage

// File: rtl/move_scheduler_tick_prescaler.sv
// tick_prescaler: free-running 0..TICK_DIV-1 counter producing a one-cycle
// tick on the terminal count. clr restarts the count from 0 so that hold
// timing can be measured from an exact edge.
module tick_prescaler
   import move_pkg::*;
#(
   parameter int TICK_DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count_reg;

   assign tick = (count_reg == LAST);

   // Count up, wrapping on the terminal count; clr has priority
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count_reg <= '0;
      else if (clr || tick)
         count_reg <= '0;
      else
         count_reg <= count_reg + CW'(1);
   end

endmodule

// File: rtl/move_scheduler.sv
// move_scheduler: turns held direction flags into rate-limited move commands
// over a valid/ready handshake and tracks the resulting grid position.
// First press issues immediately, the first repeat follows DELAY_TICKS ticks
// after its accept, later repeats follow REPEAT_TICKS ticks after theirs.
// Build option: define MOVE_WRAP_EN for wrap-around edges; otherwise the
// position saturates at the grid border and blocked reports the clamp.
module move_scheduler
   import move_pkg::*;
#(
   parameter int GRID_W       = 16,
   parameter int GRID_H       = 16,
   parameter int START_X      = 0,
   parameter int START_Y      = 0,
   parameter int TICK_DIV     = 100000,
   parameter int DELAY_TICKS  = 20,
   parameter int REPEAT_TICKS = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [3:0]                dir,
   input  logic                      move_ready,
   output logic                      move_valid,
   output logic [1:0]                move_dir,
   output logic [$clog2(GRID_W)-1:0] pos_x,
   output logic [$clog2(GRID_H)-1:0] pos_y,
   output logic                      blocked
);

   localparam int XW       = $clog2(GRID_W);
   localparam int YW       = $clog2(GRID_H);
   localparam int HOLD_MAX = (DELAY_TICKS > REPEAT_TICKS) ? DELAY_TICKS : REPEAT_TICKS;
   localparam int HW       = $clog2(HOLD_MAX + 1);

   localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
   localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);
   localparam logic [XW-1:0] X_START = XW'(START_X);
   localparam logic [YW-1:0] Y_START = YW'(START_Y);

   // Value taken when stepping off the low / high border of each axis
`ifdef MOVE_WRAP_EN
   localparam logic [XW-1:0] X_OFF_LO = X_MAX;
   localparam logic [XW-1:0] X_OFF_HI = '0;
   localparam logic [YW-1:0] Y_OFF_LO = Y_MAX;
   localparam logic [YW-1:0] Y_OFF_HI = '0;
`else
   localparam logic [XW-1:0] X_OFF_LO = '0;
   localparam logic [XW-1:0] X_OFF_HI = X_MAX;
   localparam logic [YW-1:0] Y_OFF_LO = '0;
   localparam logic [YW-1:0] Y_OFF_HI = Y_MAX;
`endif

   localparam logic [HW-1:0] DELAY_LAST  = HW'(DELAY_TICKS - 1);
   localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_TICKS - 1);

   move_state_t   state_reg, state_next;
   logic [1:0]    dir_reg, dir_next;
   logic          first_reg, first_next;
   logic [HW-1:0] hold_cnt_reg;
   logic [XW-1:0] pos_x_reg, pos_x_next;
   logic [YW-1:0] pos_y_reg, pos_y_next;
   logic          at_edge;
   logic          accept;
   logic          tick;
   logic          hold_expire;
   logic [HW-1:0] hold_last;
   resolved_t     res;

   assign res    = resolve_dir(dir);
   assign accept = (state_reg == ISSUE) && move_ready;

   // Hold timing is measured from the accept edge, so the prescaler restarts there
   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .tick (tick)
   );

   // A first press waits the long initial delay, repeats use the short period
   assign hold_last   = first_reg ? DELAY_LAST : REPEAT_LAST;
   assign hold_expire = tick && (hold_cnt_reg == hold_last);

   // Next-state logic: release, direction change, then timeout, in that order
   always_comb begin
      state_next = state_reg;
      dir_next   = dir_reg;
      first_next = first_reg;
      case (state_reg)
         IDLE: begin
            if (res.valid) begin
               dir_next   = res.dir;
               first_next = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (move_ready)
               state_next = HOLD;
         end
         HOLD: begin
            if (!res.valid)
               state_next = IDLE;
            else if (res.dir != dir_reg) begin
               dir_next   = res.dir;
               first_next = 1'b1;
               state_next = ISSUE;
            end else if (hold_expire) begin
               first_next = 1'b0;
               state_next = ISSUE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM and latched direction/first-press registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         dir_reg   <= DIR_UP;
         first_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         dir_reg   <= dir_next;
         first_reg <= first_next;
      end
   end

   // Hold counter: cleared on accept, advanced once per tick while holding
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         hold_cnt_reg <= '0;
      else if (accept)
         hold_cnt_reg <= '0;
      else if ((state_reg == HOLD) && tick)
         hold_cnt_reg <= hold_cnt_reg + HW'(1);
   end

   // Candidate position for the latched direction, with border handling
   always_comb begin
      pos_x_next = pos_x_reg;
      pos_y_next = pos_y_reg;
      at_edge    = 1'b0;
      case (dir_reg)
         DIR_UP: begin
            at_edge    = (pos_y_reg == '0);
            pos_y_next = at_edge ? Y_OFF_LO : pos_y_reg - YW'(1);
         end
         DIR_DOWN: begin
            at_edge    = (pos_y_reg == Y_MAX);
            pos_y_next = at_edge ? Y_OFF_HI : pos_y_reg + YW'(1);
         end
         DIR_LEFT: begin
            at_edge    = (pos_x_reg == '0);
            pos_x_next = at_edge ? X_OFF_LO : pos_x_reg - XW'(1);
         end
         default: begin
            at_edge    = (pos_x_reg == X_MAX);
            pos_x_next = at_edge ? X_OFF_HI : pos_x_reg + XW'(1);
         end
      endcase
   end

   // Position commits only on the handshake edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_x_reg <= X_START;
         pos_y_reg <= Y_START;
      end else if (accept) begin
         pos_x_reg <= pos_x_next;
         pos_y_reg <= pos_y_next;
      end
   end

`ifdef MOVE_WRAP_EN
   assign blocked = 1'b0;
`else
   logic blocked_reg;

   // Remember whether the most recent accepted move was clamped
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         blocked_reg <= 1'b0;
      else if (accept)
         blocked_reg <= at_edge;
   end

   assign blocked = blocked_reg;
`endif

   assign move_valid = (state_reg == ISSUE);
   assign move_dir   = dir_reg;
   assign pos_x      = pos_x_reg;
   assign pos_y      = pos_y_reg;

endmodule
